request_encoder: RTL

- Sequential N-to-log2(N) priority encoder. It is the encode-side counterpart of the team's 2-to-4 enable-gated decoder.
- Captures one-hot or multi-hot request pulses into a pending register.
- Services pending requests one at a time, highest index first.
- Presents each binary index on a valid/ready output channel.
- Sits between interrupt/event sources and any consumer that takes a binary index, including the decoder.

---
 rtl/request_encoder_if.sv | 21 ++
 rtl/request_encoder.sv | 71 +++++++
 2 files changed

// File: rtl/request_encoder_if.sv
// request_encoder output channel: binary index with valid/ready handshake.
// master drives valid/code, slave returns ready.
interface request_encoder_if #(
  parameter int W = 2
);
  logic         out_valid;
  logic [W-1:0] out_code;
  logic         out_ready;

  modport master (
    output out_valid,
    output out_code,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_code,
    output out_ready
  );
endinterface

// File: rtl/request_encoder.sv
// request_encoder: captures request pulses into a pending vector and
// serves them highest index first as binary codes on a valid/ready channel.
module request_encoder #(
  parameter int N = 4,
  parameter int W = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         enable,
  input  logic [N-1:0] req,
  request_encoder_if.master out,
  output logic [N-1:0] pending,
  output logic         overrun,
  input  logic         clr_overrun
);

  logic         valid_q;
  logic [W-1:0] code_q;
  logic [N-1:0] pend_q;
  logic         ovr_q;

  logic         free;
  logic         found;
  logic         load;
  logic [W-1:0] top;
  logic [N-1:0] set_vec;
  logic [N-1:0] clr_vec;
  logic [N-1:0] pend_d;
  logic         ovr_d;

  // Highest set index of pending; later (higher) bits overwrite lower ones.
  always_comb begin
    top = '0;
    for (int i = 0; i < N; i++) begin
      if (pend_q[i]) top = W'(i);
    end
  end

  // Load decision, pending update and overrun detection for the next edge.
  always_comb begin
    found   = |pend_q;
    free    = !valid_q || out.out_ready;
    load    = free && found;
    set_vec = req & {N{enable}};
    clr_vec = load ? (N'(1) << top) : '0;
    pend_d  = (pend_q & ~clr_vec) | set_vec;
    ovr_d   = (|(set_vec & pend_q & ~clr_vec))
            | (ovr_q & ~clr_overrun);
  end

  // State registers; every output comes straight from these.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      code_q  <= '0;
      pend_q  <= '0;
      ovr_q   <= 1'b0;
    end else begin
      pend_q <= pend_d;
      ovr_q  <= ovr_d;
      if (free) valid_q <= load;
      if (load) code_q  <= top;
    end
  end

  assign out.out_valid = valid_q;
  assign out.out_code  = code_q;
  assign pending       = pend_q;
  assign overrun       = ovr_q;

endmodule
